// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared state encoding and AXI constants for the MMU read scheduler
package mmu_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA
    } rd_state_e;

    localparam logic [2:0] AXSIZE_WORD = 3'b010;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/mmu_rd_pick.sv
// rtl/mmu_rd_pick.sv - inst/data winner select with bounded data streak
module mmu_rd_pick
    import mmu_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_en,
    input  logic i_valid,
    input  logic d_valid,
    output logic winner
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic [3:0] streak;
    logic       inst_forced;

    always_comb begin
        inst_forced = i_valid && (streak == STREAK_MAX);
        winner      = (d_valid && !inst_forced) ? OWN_DATA : OWN_INST;
    end

    // Streak only counts data wins that made a waiting inst request wait longer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_en) begin
            if (!i_valid || winner == OWN_INST) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mmu_axi_rd_sched.sv
// rtl/mmu_axi_rd_sched.sv - single-outstanding AXI read scheduler shared by inst and data controllers
module mmu_axi_rd_sched
    import mmu_pkg::*;
#(
    parameter int LINE_BEATS      = 16,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_single,
    output logic        i_req_ready,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_rlast,
    input  logic        d_req_valid,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_single,
    output logic        d_req_ready,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_rlast,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    input  logic        rlast,
    output logic        rready,
    output logic        owner,
    output logic        busy,
    output logic        proto_err
);

    localparam int             BW         = $clog2(LINE_BEATS + 1);
    localparam logic [BW-1:0]  BEATS_LINE = BW'(LINE_BEATS);
    localparam logic [BW-1:0]  BEATS_ONE  = BW'(1);
    localparam logic [7:0]     LEN_LINE   = 8'(LINE_BEATS - 1);

    rd_state_e     state, state_nx;
    logic [BW-1:0] beat_cnt;
    logic          in_idle;
    logic          req_any;
    logic          win_owner;
    logic          win_single;

    assign in_idle    = (state == RD_IDLE);
    assign req_any    = i_req_valid | d_req_valid;
    assign win_single = (win_owner == OWN_DATA) ? d_req_single : i_req_single;
    assign busy       = !in_idle;
    assign arsize     = AXSIZE_WORD;

    mmu_rd_pick #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .grant_en (in_idle),
        .i_valid  (i_req_valid),
        .d_valid  (d_req_valid),
        .winner   (win_owner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RD_IDLE;
            araddr    <= '0;
            arlen     <= '0;
            arburst   <= '0;
            owner     <= OWN_INST;
            beat_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (in_idle && req_any) begin
                owner    <= win_owner;
                araddr   <= (win_owner == OWN_DATA) ? d_req_addr : i_req_addr;
                arlen    <= win_single ? 8'd0 : LEN_LINE;
                arburst  <= win_single ? BURST_FIXED : BURST_INCR;
                beat_cnt <= win_single ? BEATS_ONE : BEATS_LINE;
            end
            // Beats past the expected count hold the counter at zero so a late rlast still flags.
            if (state == RD_DATA && rvalid) begin
                if (beat_cnt != '0) begin
                    beat_cnt <= beat_cnt - BEATS_ONE;
                end
                if ((rlast && beat_cnt != BEATS_ONE) || rresp != 2'b00) begin
                    proto_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx    = state;
        arvalid     = 1'b0;
        rready      = 1'b0;
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        i_rvalid    = 1'b0;
        i_rlast     = 1'b0;
        i_rdata     = '0;
        d_rvalid    = 1'b0;
        d_rlast     = 1'b0;
        d_rdata     = '0;
        unique case (state)
            RD_IDLE: begin
                if (req_any) state_nx = RD_ADDR;
            end
            RD_ADDR: begin
                arvalid     = 1'b1;
                i_req_ready = arready && (owner == OWN_INST);
                d_req_ready = arready && (owner == OWN_DATA);
                if (arready) state_nx = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (owner == OWN_INST) begin
                    i_rvalid = rvalid;
                    i_rlast  = rlast;
                    i_rdata  = rdata;
                end else begin
                    d_rvalid = rvalid;
                    d_rlast  = rlast;
                    d_rdata  = rdata;
                end
                if (rvalid && rlast) state_nx = RD_IDLE;
            end
            default: state_nx = RD_IDLE;
        endcase
    end

endmodule

// File: doc/mmu_axi_rd_sched.md
Name: mmu_axi_rd_sched

Overview:
- Sequenced AXI read-channel scheduler that shares the single AXI AR/R port between the instruction fetch controller and the data controller.
- Registers the winning request, drives exactly one outstanding AR transaction at a time and steers R beats back to the owner until rlast.
- Enforces data-first priority with a bounded-starvation guarantee for instruction fetch.
- Sits between the inst/data cache controllers and the AXI interconnect; the write channel is not handled here.

Parameters:
- LINE_BEATS, 16, beats per burst (cache line) read; arlen = LINE_BEATS-1.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while inst is waiting before inst is forced to win; 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_req_valid  in  1  inst read request; held with address until i_req_ready
- i_req_addr  in  32  inst physical address
- i_req_single  in  1  1 = single-beat (arlen 0, FIXED), 0 = line burst (INCR)
- i_req_ready  out  1  AR handshake for inst request completed this cycle
- i_rdata  out  32  R data to inst
- i_rvalid  out  1  R beat valid for inst
- i_rlast  out  1  last beat for inst
- d_req_valid, d_req_addr, d_req_single, d_req_ready, d_rdata, d_rvalid, d_rlast: same as the i_ ports, for the data requester
- araddr  out  32
- arlen  out  8
- arsize  out  3  constant 3'b010
- arburst  out  2
- arvalid  out  1
- arready  in  1
- rdata  in  32
- rresp  in  2
- rvalid  in  1
- rlast  in  1
- rready  out  1
- owner  out  1  0 = inst, 1 = data; valid in ADDR/DATA
- busy  out  1  state != IDLE
- proto_err  out  1  sticky: rlast beat-count mismatch or rresp != 0

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0: arvalid, araddr, arlen, arburst, rready, *_req_ready, *_rvalid, *_rlast, *_rdata, owner, busy, proto_err, streak counter, beat counter.
- The AXI transaction in flight is abandoned on reset; the interconnect shares rst.
- States:
  - IDLE: arbitrate among *_req_valid. On a win, latch address, single flag and owner, load expected beats (1 or LINE_BEATS), then go to ADDR. With no request, stay in IDLE.
  - ADDR: arvalid=1. araddr/arlen/arburst come from registers and are stable until the handshake. When arvalid&arready: pulse the owner's *_req_ready for that same cycle (combinational from arready), then go to DATA.
  - DATA: rready=1. The owner receives rdata/rvalid/rlast combinationally; the non-owner's rvalid/rlast = 0 and its rdata = 0. Each rvalid decrements the beat counter. rvalid&rlast moves to IDLE.
- Latency: request seen in IDLE at cycle t gives arvalid at t+1. After the last beat at cycle t, the next arvalid comes no earlier than t+2.
- Arbitration:
  - Data wins if d_req_valid, unless the streak counter equals MAX_DATA_STREAK and i_req_valid.
  - Inst wins if it is the only requester or the streak is exhausted.
  - Streak counter: +1 on each data grant while i_req_valid is high (saturating). Cleared on an inst grant, and in any IDLE cycle with i_req_valid low.
  - A requester dropping valid before ready is a protocol violation; behaviour is undefined and no check is required.
- proto_err sets (sticky until reset) on either condition:
  - rlast with beat counter != 1;
  - rvalid with rresp != 0.
- Data is still forwarded when proto_err is set.
- rvalid in IDLE/ADDR is ignored (rready=0).
- Simultaneous i/d request arriving in the same cycle: the rules above apply; data wins by default.

Decomposition:
- Package mmu_pkg holds:
  - state enum {RD_IDLE, RD_ADDR, RD_DATA};
  - AXI constants AXSIZE_WORD=3'b010, BURST_FIXED=2'd0, BURST_INCR=2'd1;
  - owner encoding OWN_INST=1'b0, OWN_DATA=1'b1.
- One sub-module, mmu_rd_pick: combinational winner select plus the registered streak counter; inputs valids and a grant strobe, output the winner.

Test Plan:
- Inst-only line read at addr 0x1FC0_0000, arready=1 -> arvalid one cycle after request, arlen=15, arburst=1; 16 beats to i_*, i_rlast on beat 16; d_rvalid stays 0.
- Simultaneous i/d requests, d single at 0x1FAF_0000 -> data granted first (arlen=0, arburst=0, owner=1); inst is granted in the ADDR following data's rlast, with 2 cycles of arvalid low.
- d_req_valid held continuously with i pending, MAX_DATA_STREAK=4 -> grants D,D,D,D,I,D...; the streak counter clears after the inst grant.
- arready low for 5 cycles in ADDR -> araddr/arlen stable; d_req_ready pulses exactly once, in the cycle arready=1.
- Line read with rlast on beat 15 -> proto_err=1 and stays 1 across later clean transactions; rresp=2'b10 on a single read also sets proto_err.
- rst asserted during beat 7 of a burst -> arvalid, rready and busy go to 0 immediately; after deassertion, a new request starts cleanly from IDLE.
